rx_os_consensus: RTL and testbench

Parametrised multi-lane ordered-set consensus engine for the receive-side LTSSM. It succeeds the fixed 16-lane per-lane checker/counter/comparator arrangement with a single block that provides:
- a configurable lane count, ordered-set width and counter width;
- selectable counting modes;
- an all-lanes/any-lane quorum;
- a built-in timeout.

The master RX state machine pulses `start` on substate entry and gets back a single `done` with success or timeout status plus per-lane qualification.

---
 rtl/rx_os_consensus_pkg.sv | 16 +
 rtl/rx_os_consensus_if.sv | 34 +++
 rtl/rx_os_consensus_lane_counter.sv | 67 ++++++
 rtl/rx_os_consensus.sv | 102 ++++++++++
 tb/tb_rx_os_consensus.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/rx_os_consensus_pkg.sv
// Shared encodings for the receive-side ordered-set consensus engine.
package rx_os_pkg;

    localparam int MAX_LANES = 32;

    localparam logic [1:0] MODE_CUMUL  = 2'd0;
    localparam logic [1:0] MODE_CONSEC = 2'd1;
    localparam logic [1:0] MODE_IDENT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rx_os_consensus_if.sv
// Control/status and aligned ordered-set bus between the RX LTSSM and the consensus engine.
interface rx_os_consensus_if #(
    parameter int LANES     = 16,
    parameter int OS_WIDTH  = 128,
    parameter int CNT_WIDTH = 5,
    parameter int TMR_WIDTH = 24
);
    logic                      start;
    logic [1:0]                mode;
    logic                      require_all;
    logic [LANES-1:0]          lane_mask;
    logic [CNT_WIDTH-1:0]      target_count;
    logic [TMR_WIDTH-1:0]      timeout_cycles;
    logic                      os_valid;
    logic [LANES-1:0]          os_match;
    logic [LANES*OS_WIDTH-1:0] os_data;
    logic                      busy;
    logic                      done;
    logic                      success;
    logic                      timed_out;
    logic [LANES-1:0]          lane_qualified;

    modport master (
        output start, mode, require_all, lane_mask, target_count, timeout_cycles,
        output os_valid, os_match, os_data,
        input  busy, done, success, timed_out, lane_qualified
    );

    modport slave (
        input  start, mode, require_all, lane_mask, target_count, timeout_cycles,
        input  os_valid, os_match, os_data,
        output busy, done, success, timed_out, lane_qualified
    );
endinterface

// File: rtl/rx_os_consensus_lane_counter.sv
// One lane: stored ordered set, identical-set compare, saturating counter, qualify flag.
module rx_os_lane_counter
    import rx_os_pkg::*;
#(
    parameter int OS_WIDTH  = 128,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr_i,
    input  logic                 upd_i,
    input  logic [1:0]           mode_i,
    input  logic                 match_i,
    input  logic [OS_WIDTH-1:0]  data_i,
    input  logic [CNT_WIDTH-1:0] target_i,
    input  logic                 mask_i,
    output logic                 qual_o
);
    logic [OS_WIDTH-1:0]  prev_q, prev_d;
    logic                 has_prev_q, has_prev_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic                 qual_q, qual_d;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        cnt_d      = cnt_q;
        prev_d     = prev_q;
        has_prev_d = has_prev_q;
        if (clr_i) begin
            cnt_d      = '0;
            prev_d     = '0;
            has_prev_d = 1'b0;
        end else if (upd_i) begin
            prev_d     = data_i;
            has_prev_d = 1'b1;
            case (mode_i)
                MODE_CUMUL: if (match_i) cnt_d = cnt_inc;
                // the first set after a clear has nothing to compare against, so it restarts at 1
                MODE_IDENT: begin
                    if (!match_i)                            cnt_d = '0;
                    else if (has_prev_q && data_i == prev_q) cnt_d = cnt_inc;
                    else                                     cnt_d = CNT_WIDTH'(1);
                end
                default:    cnt_d = match_i ? cnt_inc : '0;
            endcase
        end
        qual_d = mask_i && (cnt_d >= target_i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q     <= '0;
            has_prev_q <= 1'b0;
            cnt_q      <= '0;
            qual_q     <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            has_prev_q <= has_prev_d;
            cnt_q      <= cnt_d;
            qual_q     <= qual_d;
        end
    end

    assign qual_o = qual_q;

endmodule

// File: rtl/rx_os_consensus.sv
// Multi-lane ordered-set consensus: FSM, timeout timer, quorum reduction and held status.
module rx_os_consensus
    import rx_os_pkg::*;
#(
    parameter int LANES     = 16,
    parameter int OS_WIDTH  = 128,
    parameter int CNT_WIDTH = 5,
    parameter int TMR_WIDTH = 24
) (
    input  logic            clk,
    input  logic            reset,
    rx_os_consensus_if.slave bus
);
    state_e               state_q, state_d;
    logic [TMR_WIDTH-1:0] tmr_q, tmr_d;
    logic                 success_q, success_d;
    logic                 timed_out_q, timed_out_d;
    logic [LANES-1:0]     qual;
    logic [LANES-1:0]     masked;
    logic                 run, upd, quorum, expire;

    assign run = (state_q == ST_RUN);
    // a restart clears the lanes even if a set arrives on the same edge
    assign upd = run && bus.os_valid && !bus.start;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        rx_os_lane_counter #(
            .OS_WIDTH  (OS_WIDTH),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .clr_i    (bus.start),
            .upd_i    (upd),
            .mode_i   (bus.mode),
            .match_i  (bus.os_match[gi]),
            .data_i   (bus.os_data[gi*OS_WIDTH +: OS_WIDTH]),
            .target_i (bus.target_count),
            .mask_i   (bus.lane_mask[gi]),
            .qual_o   (qual[gi])
        );
    end

    always_comb begin
        masked = qual & bus.lane_mask;
        if (bus.lane_mask == '0)  quorum = 1'b0;
        else if (bus.require_all) quorum = (masked == bus.lane_mask);
        else                      quorum = |masked;
    end

    // a zero load never reaches 1, so the timer stays disarmed
    assign expire = run && (tmr_q == TMR_WIDTH'(1));

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        success_d   = success_q;
        timed_out_d = timed_out_q;
        if (bus.start) begin
            state_d     = ST_RUN;
            tmr_d       = bus.timeout_cycles;
            success_d   = 1'b0;
            timed_out_d = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
                    if (quorum) begin
                        state_d   = ST_DONE;
                        success_d = 1'b1;
                    end else if (expire) begin
                        state_d     = ST_DONE;
                        timed_out_d = 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            success_q   <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            success_q   <= success_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign bus.busy           = run;
    assign bus.done           = (state_q == ST_DONE);
    assign bus.success        = success_q;
    assign bus.timed_out      = timed_out_q;
    assign bus.lane_qualified = qual;

endmodule

// File: tb/tb_rx_os_consensus.sv
// Bench for rx_os_consensus: vector table of runs plus hand sequences for abort, reset and saturation.
module tb_rx_os_consensus;
    import rx_os_pkg::*;

    localparam int L  = 4;
    localparam int OW = 16;
    localparam int CW = 5;
    localparam int TW = 24;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rx_os_consensus_if #(.LANES(L), .OS_WIDTH(OW), .CNT_WIDTH(CW), .TMR_WIDTH(TW)) bus();

    rx_os_consensus #(.LANES(L), .OS_WIDTH(OW), .CNT_WIDTH(CW), .TMR_WIDTH(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic         succ;
        logic         to;
        int           lat;
        logic [L-1:0] lq;
    } exp_t;

    typedef struct {
        logic [1:0]    mode;
        logic          all;
        logic [L-1:0]  mask;
        logic [CW-1:0] tgt;
        int            tmo;
        logic [L-1:0]  match;
        logic          alt;
        logic [L-1:0]  mis;
        int            mis_at;
        int            n;
        exp_t          e;
    } vec_t;

    exp_t sb[$];
    vec_t vt[12];
    int   tests = 0, fails = 0;
    int   cyc = 0, start_cyc = 0, done_cnt = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: each done pops the expectation pushed when its run was started
    always @(negedge clk) begin
        exp_t e;
        if (reset && bus.done) begin
            done_cnt++;
            chk("done_pulse_width", {31'd0, prev_done}, 32'd0);
            chk("busy_low_at_done", {31'd0, bus.busy}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("success", {31'd0, bus.success}, {31'd0, e.succ});
                chk("timed_out", {31'd0, bus.timed_out}, {31'd0, e.to});
                chk("lane_qualified", {28'd0, bus.lane_qualified}, {28'd0, e.lq});
                if (e.lat >= 0) chk("latency", cyc - start_cyc, e.lat);
            end
        end
        prev_done = bus.done;
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int k = 0; k < 300 && done_cnt == d0; k++) @(negedge clk);
        chk("done_seen", {31'd0, done_cnt != d0}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic setup(input logic [1:0] m, input logic a, input logic [L-1:0] mk,
                         input logic [CW-1:0] t, input int tmo);
        bus.mode           = m;
        bus.require_all    = a;
        bus.lane_mask      = mk;
        bus.target_count   = t;
        bus.timeout_cycles = TW'(tmo);
    endtask

    task automatic drive_valid(input logic [L-1:0] m, input logic [OW-1:0] d);
        bus.os_valid = 1'b1;
        bus.os_match = m;
        bus.os_data  = {L{d}};
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int d0;
        logic [L-1:0] m;
        @(negedge clk);
        setup(v.mode, v.all, v.mask, v.tgt, v.tmo);
        sb.push_back(v.e);
        d0 = done_cnt;
        pulse_start();
        for (int i = 1; i <= v.n; i++) begin
            m = (i == v.mis_at) ? (v.match & ~v.mis) : v.match;
            drive_valid(m, (v.alt && (i % 2 == 1)) ? 16'hA5A5 : 16'h3C3C);
        end
        bus.os_valid = 1'b0;
        bus.os_match = '0;
        wait_done(d0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        //          mode  all   mask     tgt  tmo match    alt   mis      at  n   {succ,to,lat,lq}
        vt[0]  = '{2'd1, 1'b1, 4'b1111, 5'd8, 0,  4'b1111, 1'b0, 4'b0000, 0, 8,  '{1'b1, 1'b0, 9,  4'b1111}};
        vt[1]  = '{2'd1, 1'b1, 4'b1111, 5'd8, 0,  4'b1111, 1'b0, 4'b0100, 6, 14, '{1'b1, 1'b0, 15, 4'b1111}};
        vt[2]  = '{2'd0, 1'b0, 4'b0100, 5'd3, 0,  4'b0100, 1'b0, 4'b0000, 0, 3,  '{1'b1, 1'b0, 4,  4'b0100}};
        vt[3]  = '{2'd0, 1'b0, 4'b0000, 5'd3, 10, 4'b0100, 1'b0, 4'b0000, 0, 3,  '{1'b0, 1'b1, 10, 4'b0000}};
        vt[4]  = '{2'd2, 1'b1, 4'b0001, 5'd3, 20, 4'b0001, 1'b1, 4'b0000, 0, 19, '{1'b0, 1'b1, 20, 4'b0000}};
        vt[5]  = '{2'd2, 1'b1, 4'b1111, 5'd4, 0,  4'b1111, 1'b0, 4'b0000, 0, 4,  '{1'b1, 1'b0, 5,  4'b1111}};
        vt[6]  = '{2'd0, 1'b1, 4'b1111, 5'd4, 0,  4'b1111, 1'b0, 4'b1111, 3, 5,  '{1'b1, 1'b0, 6,  4'b1111}};
        vt[7]  = '{2'd1, 1'b1, 4'b1111, 5'd4, 12, 4'b1111, 1'b0, 4'b1111, 3, 5,  '{1'b0, 1'b1, 12, 4'b0000}};
        vt[8]  = '{2'd3, 1'b1, 4'b0011, 5'd2, 0,  4'b1111, 1'b0, 4'b0000, 0, 2,  '{1'b1, 1'b0, 3,  4'b0011}};
        vt[9]  = '{2'd1, 1'b1, 4'b1010, 5'd0, 0,  4'b0000, 1'b0, 4'b0000, 0, 0,  '{1'b1, 1'b0, 1,  4'b1010}};
        vt[10] = '{2'd1, 1'b1, 4'b1111, 5'd4, 5,  4'b1111, 1'b0, 4'b0000, 0, 4,  '{1'b1, 1'b0, 5,  4'b1111}};
        vt[11] = '{2'd1, 1'b1, 4'b0011, 5'd2, 6,  4'b0001, 1'b0, 4'b0000, 0, 5,  '{1'b0, 1'b1, 6,  4'b0001}};

        bus.start    = 1'b0;
        bus.os_valid = 1'b0;
        bus.os_match = '0;
        bus.os_data  = '0;
        setup(2'd1, 1'b1, 4'b1111, 5'd0, 0);

        // reset values, with inputs that would otherwise make lanes qualify
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_success", {31'd0, bus.success}, 32'd0);
        chk("rst_timed_out", {31'd0, bus.timed_out}, 32'd0);
        chk("rst_lane_qualified", {28'd0, bus.lane_qualified}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 12; v++) run_vec(vt[v]);

        // restart mid-RUN: the aborted run must not complete and counters must restart from 0
        setup(2'd1, 1'b1, 4'b1111, 5'd3, 0);
        pulse_start();
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
        drive_valid(4'b1111, 16'h1111);
        drive_valid(4'b1111, 16'h1111);
        sb.push_back('{1'b1, 1'b0, 4, 4'b1111});
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 3; i++) drive_valid(4'b1111, 16'h1111);
        bus.os_valid = 1'b0;
        wait_done(d0);
        chk("abort_single_done", done_cnt - d0, 32'd1);

        // asynchronous reset mid-RUN with lanes 0..2 at count 6
        setup(2'd1, 1'b1, 4'b1111, 5'd6, 0);
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 6; i++) drive_valid(4'b0111, 16'h2222);
        bus.os_valid = 1'b0;
        chk("pre_reset_lq", {28'd0, bus.lane_qualified}, 32'h7);
        chk("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        chk("mid_rst_success", {31'd0, bus.success}, 32'd0);
        chk("mid_rst_timed_out", {31'd0, bus.timed_out}, 32'd0);
        chk("mid_rst_lq", {28'd0, bus.lane_qualified}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_done_on_reset", done_cnt - d0, 32'd0);

        // saturation: 40 cumulative matches must hold at 31, not wrap
        setup(2'd0, 1'b1, 4'b1111, 5'd31, 0);
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 40; i++) drive_valid(4'b0111, 16'h3333);
        bus.os_valid = 1'b0;
        chk("sat_lq", {28'd0, bus.lane_qualified}, 32'h7);
        chk("sat_still_busy", {31'd0, bus.busy}, 32'd1);
        chk("sat_no_done", done_cnt - d0, 32'd0);
        sb.push_back('{1'b1, 1'b0, -1, 4'b0111});
        bus.lane_mask = 4'b0111;
        wait_done(d0);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
